// File: rtl/dca_matrix_lsu_txn_sched_if.sv
// Descriptor and transaction channels between the LSU read-request generator
// and the matrix transaction sequencer.
interface dca_matrix_lsu_txn_sched_if #(
  parameter int BW_ADDR   = 32,
  parameter int BW_NUM    = 16,
  parameter int BW_STRIDE = 16
);
  logic                 inst_valid;
  logic                 inst_ready;
  logic [BW_ADDR-1:0]   inst_addr;
  logic [BW_STRIDE-1:0] inst_stride;
  logic [BW_NUM-1:0]    inst_num_row_m1;
  logic [BW_NUM-1:0]    inst_num_col_m1;
  logic                 abort;
  logic                 txn_valid;
  logic                 txn_ready;
  logic [BW_ADDR+2:0]   txn_bitaddr;
  logic [7:0]           txn_alen;
  logic                 txn_last_in_row;
  logic                 txn_last;
  logic                 busy;
  logic                 done;

  modport master (
    output inst_valid, inst_addr, inst_stride, inst_num_row_m1, inst_num_col_m1,
    output abort, txn_ready,
    input  inst_ready, txn_valid, txn_bitaddr, txn_alen, txn_last_in_row, txn_last,
    input  busy, done
  );

  modport slave (
    input  inst_valid, inst_addr, inst_stride, inst_num_row_m1, inst_num_col_m1,
    input  abort, txn_ready,
    output inst_ready, txn_valid, txn_bitaddr, txn_alen, txn_last_in_row, txn_last,
    output busy, done
  );
endinterface

// File: rtl/dca_matrix_lsu_txn_sched.sv
// Matrix read descriptor -> row-major stream of AXI-sized burst transactions.
// Define DCA_LSU_TXN_4KB_SPLIT_EN to additionally split bursts at 4KB boundaries.
module dca_matrix_lsu_txn_sched #(
  parameter int BW_ADDR        = 32,
  parameter int BW_DATA        = 32,
  parameter int BW_NUM         = 16,
  parameter int BW_STRIDE      = 16,
  parameter int ELEM_SIZE_LOG2 = 2,
  parameter int MAX_BURST      = 16
) (
  input logic clk,
  input logic rstnn,
  dca_matrix_lsu_txn_sched_if.slave bus
);
  localparam int BYTES_PER_BEAT = BW_DATA / 8;
  localparam int LOG2_BPB       = $clog2(BYTES_PER_BEAT);
  localparam int W_ROW_BYTES    = BW_NUM + ELEM_SIZE_LOG2 + 2;
  localparam int W_BEATS_RAW    = BW_NUM + ELEM_SIZE_LOG2 + 1;
  localparam int W_BEATS        = (W_BEATS_RAW > 14) ? W_BEATS_RAW : 14;
  localparam int W_BURST        = 9;
  localparam logic [BW_ADDR-1:0] ADDR_MASK = ~BW_ADDR'(BYTES_PER_BEAT - 1);

  typedef enum logic {IDLE, ISSUE} state_t;

  state_t               state;
  logic                 inst_ready_q;
  logic                 done_q;
  logic [BW_ADDR+2:0]   txn_bitaddr_q;
  logic [7:0]           txn_alen_q;
  logic                 txn_lir_q;
  logic                 txn_last_q;

  logic [BW_ADDR-1:0]   row_base;
  logic [BW_ADDR-1:0]   cur_addr;
  logic [BW_ADDR-1:0]   stride_q;
  logic [BW_NUM-1:0]    num_row_m1_q;
  logic [BW_NUM-1:0]    row_cnt;
  logic [W_BEATS-1:0]   row_beats_q;
  logic [W_BEATS-1:0]   beats_left;

  logic                 inst_fire;
  logic                 txn_fire;
  logic [W_ROW_BYTES-1:0] inst_row_bytes;
  logic [W_BEATS-1:0]   inst_row_beats;
  logic [W_BURST-1:0]   cur_burst;

  logic [BW_ADDR-1:0]   nxt_addr;
  logic [BW_ADDR-1:0]   nxt_row_base;
  logic [W_BEATS-1:0]   nxt_beats;
  logic [BW_NUM-1:0]    nxt_row_cnt;
  logic [BW_NUM-1:0]    nxt_num_row;
  logic [W_BEATS-1:0]   nxt_room;
  logic [W_BEATS-1:0]   nxt_lim;
  logic [W_BURST-1:0]   nxt_burst;
  logic                 nxt_lir;
  logic                 nxt_last;

  assign inst_fire = (state == IDLE) && inst_ready_q && bus.inst_valid && !bus.abort;
  assign txn_fire  = (state == ISSUE) && bus.txn_ready;

  // Row length in beats, rounded up; sized so an all-ones column count cannot overflow.
  assign inst_row_bytes = (W_ROW_BYTES'(bus.inst_num_col_m1) + W_ROW_BYTES'(1)) << ELEM_SIZE_LOG2;
  assign inst_row_beats = W_BEATS'((inst_row_bytes + W_ROW_BYTES'(BYTES_PER_BEAT - 1)) >> LOG2_BPB);

  assign cur_burst = W_BURST'(txn_alen_q) + W_BURST'(1);

`ifdef DCA_LSU_TXN_4KB_SPLIT_EN
  // cur_addr is beat-aligned, so the remaining page room is an exact beat count.
  assign nxt_room = W_BEATS'((13'h1000 - {1'b0, nxt_addr[11:0]}) >> LOG2_BPB);
`else
  assign nxt_room = '1;
`endif

  // Position of the transaction that will be presented after this cycle.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    nxt_addr     = cur_addr;
    nxt_row_base = row_base;
    nxt_beats    = beats_left;
    nxt_row_cnt  = row_cnt;
    nxt_num_row  = num_row_m1_q;
    if (inst_fire) begin
      nxt_addr     = bus.inst_addr & ADDR_MASK;
      nxt_row_base = bus.inst_addr & ADDR_MASK;
      nxt_beats    = inst_row_beats;
      nxt_row_cnt  = '0;
      nxt_num_row  = bus.inst_num_row_m1;
    end else if (txn_fire) begin
      if (!txn_lir_q) begin
        nxt_addr  = cur_addr + (BW_ADDR'(cur_burst) << LOG2_BPB);
        nxt_beats = beats_left - W_BEATS'(cur_burst);
      end else begin
        nxt_row_base = row_base + stride_q;
        nxt_addr     = row_base + stride_q;
        nxt_row_cnt  = row_cnt + BW_NUM'(1);
        nxt_beats    = row_beats_q;
      end
    end

    nxt_lim = (nxt_beats < W_BEATS'(MAX_BURST)) ? nxt_beats : W_BEATS'(MAX_BURST);
    if (nxt_room < nxt_lim) nxt_lim = nxt_room;
    nxt_burst = W_BURST'(nxt_lim);
    // A page split leaves beats behind, so it can never look like end of row.
    nxt_lir   = (nxt_lim == nxt_beats);
    nxt_last  = nxt_lir && (nxt_row_cnt == nxt_num_row);
  end

  always_ff @(posedge clk) begin
    if (!rstnn) begin
      state         <= IDLE;
      inst_ready_q  <= 1'b0;
      done_q        <= 1'b0;
      txn_bitaddr_q <= '0;
      txn_alen_q    <= '0;
      txn_lir_q     <= 1'b0;
      txn_last_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (bus.abort) begin
        state         <= IDLE;
        inst_ready_q  <= 1'b1;
        txn_bitaddr_q <= '0;
        txn_alen_q    <= '0;
        txn_lir_q     <= 1'b0;
        txn_last_q    <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            inst_ready_q <= 1'b1;
            if (inst_fire) begin
              state         <= ISSUE;
              inst_ready_q  <= 1'b0;
              txn_bitaddr_q <= {nxt_addr, 3'b000};
              txn_alen_q    <= 8'(nxt_burst - W_BURST'(1));
              txn_lir_q     <= nxt_lir;
              txn_last_q    <= nxt_last;
            end
          end
          ISSUE: begin
            if (txn_fire) begin
              if (txn_last_q) begin
                state         <= IDLE;
                inst_ready_q  <= 1'b1;
                done_q        <= 1'b1;
                txn_bitaddr_q <= '0;
                txn_alen_q    <= '0;
                txn_lir_q     <= 1'b0;
                txn_last_q    <= 1'b0;
              end else begin
                txn_bitaddr_q <= {nxt_addr, 3'b000};
                txn_alen_q    <= 8'(nxt_burst - W_BURST'(1));
                txn_lir_q     <= nxt_lir;
                txn_last_q    <= nxt_last;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // NOTE: walk registers carry no reset; they are always loaded on accept before use.
  always_ff @(posedge clk) begin
    if (inst_fire) begin
      stride_q     <= BW_ADDR'(bus.inst_stride) & ADDR_MASK;
      row_beats_q  <= inst_row_beats;
    end
    if (inst_fire || txn_fire) begin
      cur_addr     <= nxt_addr;
      row_base     <= nxt_row_base;
      beats_left   <= nxt_beats;
      row_cnt      <= nxt_row_cnt;
      num_row_m1_q <= nxt_num_row;
    end
  end

  assign bus.inst_ready      = inst_ready_q;
  assign bus.txn_valid       = (state == ISSUE);
  assign bus.busy            = (state == ISSUE);
  assign bus.done            = done_q;
  assign bus.txn_bitaddr     = txn_bitaddr_q;
  assign bus.txn_alen        = txn_alen_q;
  assign bus.txn_last_in_row = txn_lir_q;
  assign bus.txn_last        = txn_last_q;
endmodule

// File: tb/tb_dca_matrix_lsu_txn_sched.sv
// Scoreboard bench for dca_matrix_lsu_txn_sched: a descriptor-level model fills
// an expected queue, a monitor compares every presented transaction.
`timescale 1ns/1ps
module tb_dca_matrix_lsu_txn_sched;
  typedef struct packed {
    logic [34:0] bitaddr;
    logic [7:0]  alen;
    logic        lir;
    logic        last;
  } txn_t;

  logic clk = 1'b0;
  logic rstnn = 1'b0;
  always #5 clk = ~clk;

  dca_matrix_lsu_txn_sched_if #(.BW_ADDR(32), .BW_NUM(16), .BW_STRIDE(16)) bus ();

  dca_matrix_lsu_txn_sched dut (
    .clk   (clk),
    .rstnn (rstnn),
    .bus   (bus)
  );

  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   hs_cnt = 0;
  int   last_hs_cyc = -100;
  int   rise_cyc = -100;
  bit   done_exp = 1'b0;
  bit   prev_valid = 1'b0;
  bit   rand_ready = 1'b0;
  txn_t got;
  txn_t exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: rows start at base + r*stride, each row cut into bursts of at most
  // 16 beats (and never across a 4KB page when the split is enabled).
  function automatic int model(input logic [31:0] addr, input logic [15:0] stride,
                               input int row_m1, input int col_m1);
    longint unsigned base, st, ra;
    int   beats, b, room, n;
    txn_t t;
    n    = 0;
    base = longint'(addr) & 64'hFFFF_FFFC;
    st   = longint'(stride) & 64'hFFFC;
    for (int r = 0; r <= row_m1; r++) begin
      ra    = (base + longint'(r) * st) % 64'h1_0000_0000;
      beats = ((col_m1 + 1) * 4 + 3) / 4;
      while (beats > 0) begin
        b = (beats < 16) ? beats : 16;
`ifdef DCA_LSU_TXN_4KB_SPLIT_EN
        room = (4096 - int'(ra % 4096)) / 4;
        if (room < b) b = room;
`else
        room = 0;
`endif
        t.bitaddr = 35'(ra << 3);
        t.alen    = 8'(b - 1);
        t.lir     = (b == beats);
        t.last    = t.lir && (r == row_m1);
        exp_q.push_back(t);
        n++;
        ra    = (ra + longint'(b) * 4) % 64'h1_0000_0000;
        beats = beats - b;
      end
    end
    return n + room * 0;
  endfunction

  // Monitor: every presented transaction must match the queue head; pop on handshake.
  always @(negedge clk) begin
    if (done_exp || bus.done) check("done_pulse", 64'(bus.done), 64'(done_exp));
    done_exp = 1'b0;
    if (bus.txn_valid) begin
      if (!prev_valid) rise_cyc = cyc;
      if (exp_q.size() == 0) begin
        check("unexpected_txn", 64'(bus.txn_valid), 64'd0);
      end else begin
        got = {bus.txn_bitaddr, bus.txn_alen, bus.txn_last_in_row, bus.txn_last};
        check("txn", 64'(got), 64'(exp_q[0]));
        if (bus.txn_ready) begin
          if (exp_q[0].last) begin
            done_exp    = 1'b1;
            last_hs_cyc = cyc;
          end
          void'(exp_q.pop_front());
          hs_cnt++;
        end
      end
    end
    prev_valid = bus.txn_valid;
  end

  task automatic step();
    @(posedge clk);
    #1;
    if (rand_ready) bus.txn_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic send(input logic [31:0] addr, input logic [15:0] stride,
                      input int row_m1, input int col_m1, output int acc_cyc, output int n);
    bus.inst_addr       = addr;
    bus.inst_stride     = stride;
    bus.inst_num_row_m1 = 16'(row_m1);
    bus.inst_num_col_m1 = 16'(col_m1);
    bus.inst_valid      = 1'b1;
    acc_cyc = -1;
    n = 0;
    for (int i = 0; i < 300 && acc_cyc < 0; i++) begin
      if (bus.inst_ready) begin
        acc_cyc = cyc;
        n = model(addr, stride, row_m1, col_m1);
      end
      step();
    end
    bus.inst_valid = 1'b0;
    if (acc_cyc < 0) check("accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic drain();
    int k = 0;
    while ((exp_q.size() != 0 || bus.txn_valid) && k < 20000) begin
      step();
      k++;
    end
    step();
    step();
    check("drain", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic wait_hs(input int target);
    int k = 0;
    while (hs_cnt < target && k < 200) begin
      step();
      k++;
    end
    check("wait_hs", 64'(hs_cnt >= target), 64'd1);
  endtask

  task automatic run(input logic [31:0] addr, input logic [15:0] stride,
                     input int row_m1, input int col_m1, input string name);
    int h0, a, n;
    h0 = hs_cnt;
    send(addr, stride, row_m1, col_m1, a, n);
    drain();
    check(name, 64'(hs_cnt - h0), 64'(n));
  endtask

  initial begin : stim
    int h0, a, n, a2, n2, lh;
    logic [31:0] addr;
    bus.inst_valid = 1'b0;
    bus.inst_addr = '0;
    bus.inst_stride = '0;
    bus.inst_num_row_m1 = '0;
    bus.inst_num_col_m1 = '0;
    bus.abort = 1'b0;
    bus.txn_ready = 1'b0;

    step();
    step();
    check("reset_outputs", 64'({bus.inst_ready, bus.txn_valid, bus.txn_bitaddr, bus.txn_alen,
                               bus.txn_last_in_row, bus.txn_last, bus.busy, bus.done}), 64'd0);
    rstnn = 1'b1;
    step();
    check("ready_after_reset", 64'(bus.inst_ready), 64'd1);
    bus.txn_ready = 1'b1;

    run(32'h0000_1000, 16'h0100, 1, 2, "count_two_rows");
    run(32'h0000_1000, 16'h0000, 0, 39, "count_row_split");
    run(32'h0000_1FF0, 16'h0000, 0, 7, "count_4kb");
    run(32'h0000_0013, 16'h0107, 2, 5, "count_unaligned");

    // Backpressure mid-row: the stalled transaction is re-checked every cycle.
    h0 = hs_cnt;
    send(32'h0000_3000, 16'h0040, 0, 39, a, n);
    wait_hs(h0 + 1);
    bus.txn_ready = 1'b0;
    repeat (5) step();
    bus.txn_ready = 1'b1;
    drain();
    check("count_backpressure", 64'(hs_cnt - h0), 64'(n));

    // Abort while the third transaction of a 3x3 descriptor is pending.
    h0 = hs_cnt;
    send(32'h0000_4000, 16'h0020, 2, 2, a, n);
    wait_hs(h0 + 2);
    bus.txn_ready = 1'b0;
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    exp_q.delete();
    check("abort_state", 64'({bus.txn_valid, bus.busy, bus.inst_ready}), 64'b001);
    step();
    check("abort_no_done", 64'(bus.done), 64'd0);
    bus.txn_ready = 1'b1;
    run(32'h0000_8000, 16'h0010, 1, 1, "count_after_abort");

    // Synchronous reset in the middle of a descriptor.
    h0 = hs_cnt;
    send(32'h0000_5000, 16'h0040, 2, 20, a, n);
    wait_hs(h0 + 2);
    bus.txn_ready = 1'b0;
    rstnn = 1'b0;
    step();
    exp_q.delete();
    step();
    check("midrun_reset_outputs", 64'({bus.inst_ready, bus.txn_valid, bus.txn_bitaddr, bus.txn_alen,
                                      bus.txn_last_in_row, bus.txn_last, bus.busy, bus.done}), 64'd0);
    rstnn = 1'b1;
    step();
    check("ready_after_midrun_reset", 64'(bus.inst_ready), 64'd1);
    bus.txn_ready = 1'b1;
    run(32'h0000_9000, 16'h0080, 1, 3, "count_after_reset");

    // Back-to-back: second descriptor held valid while the first is issuing.
    send(32'h0000_1000, 16'h0100, 1, 2, a, n);
    send(32'h0000_6000, 16'h0000, 0, 39, a2, n2);
    lh = last_hs_cyc;
    drain();
    check("b2b_accept_cycle", 64'(a2), 64'(lh + 1));
    check("b2b_first_txn_cycle", 64'(rise_cyc), 64'(lh + 2));

    // Widest row: column count all-ones.
    run(32'h0000_0010, 16'h0000, 0, 65535, "count_max_cols");

    // Randomized descriptors with random downstream backpressure.
    rand_ready = 1'b1;
    for (int i = 0; i < 30; i++) begin
      case ($urandom_range(0, 2))
        0:       addr = $urandom;
        1:       addr = {$urandom_range(0, 65535), 4'h0, 12'(12'hF00 + $urandom_range(0, 255))};
        default: addr = 32'hFFFF_FF00 + 32'($urandom_range(0, 255));
      endcase
      run(addr, 16'($urandom), $urandom_range(0, 3), $urandom_range(0, 70), "count_random");
    end
    rand_ready = 1'b0;
    bus.txn_ready = 1'b1;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin : watchdog
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end
endmodule
